ex_mem_skid_reg: RTL

//  EX->MEM boundary register for the rv32i pipeline; receiving end of the EX stage outputs.

---
 rtl/ex_mem_skid_reg.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX->MEM pipeline boundary register with 2-entry skid buffer
//
// Purpose:
//   Captures the EX stage results (ALU result, branch compare, PC, store data,
//   control word) into a head register that drives MEM directly, plus a skid
//   register that absorbs one extra instruction so MEM backpressure never
//   reaches EX combinationally. Handshake outputs decode only state flops.
//
// Optional feature:
//   EXMEM_PERF_CNT_EN - when defined, builds the stall and flush performance
//   counters; when undefined, perf_stall_cnt / perf_flush_cnt are tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of buffered entries and current input
//   ex_valid/ex_ready EX-side handshake (ex_ready = state != FULL)
//   ex_alu_out, ex_br_en, idex_pc, idex_rs2_out, idex_ctrl_word   input payload
//   mem_valid/mem_ready MEM-side handshake (mem_valid = state != EMPTY)
//   exmem_alu_out, exmem_br_en, exmem_pc, exmem_rs2_out, exmem_ctrl_word   head payload
//   perf_stall_cnt    cycles with mem_valid & !mem_ready
//   perf_flush_cnt    entries discarded by flush

module ex_mem_skid_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic              ex_br_en,
    input  logic [XLEN-1:0]   idex_pc,
    input  logic [XLEN-1:0]   idex_rs2_out,
    input  logic [CTRL_W-1:0] idex_ctrl_word,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   exmem_alu_out,
    output logic              exmem_br_en,
    output logic [XLEN-1:0]   exmem_pc,
    output logic [XLEN-1:0]   exmem_rs2_out,
    output logic [CTRL_W-1:0] exmem_ctrl_word,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    localparam int PW = 3 * XLEN + 1 + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] head_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_word;
    logic          push;
    logic          pop;

    assign in_word = {ex_alu_out, ex_br_en, idex_pc, idex_rs2_out, idex_ctrl_word};

    // Handshake outputs are pure decodes of the state register, so neither
    // side sees a combinational path from the other side's inputs.
    assign ex_ready  = (state != FULL);
    assign mem_valid = (state != EMPTY);

    assign push = ex_valid & ex_ready;
    assign pop  = mem_valid & mem_ready;

    // Head register feeds MEM with no output mux.
    assign {exmem_alu_out, exmem_br_en, exmem_pc, exmem_rs2_out, exmem_ctrl_word} = head_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Payload left untouched; only occupancy is killed.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q <= in_word;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= in_word;
                    end else if (push) begin
                        skid_q <= in_word;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // ex_ready is low here, so no push can coincide.
                    if (pop) begin
                        head_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [1:0]  occupancy;
    logic [1:0]  flush_drop;

    // An entry popped in the flush cycle was consumed by MEM, not discarded.
    always_comb begin
        occupancy  = 2'd0;
        if (state == FULL) begin
            occupancy = 2'd2;
        end else if (state == ONE) begin
            occupancy = 2'd1;
        end
        flush_drop = occupancy - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (mem_valid && !mem_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + {30'd0, flush_drop};
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
